// File: rtl/frac_conv_pkg.sv
// Shared constants, derived datapath widths and window tap mapping for the
// fractional-order 3x3 convolution block.
package frac_conv_pkg;

  localparam int TAPS  = 9;
  localparam int PIX_W = 8;

  // Tap index equals window byte index: byte 0 is the newest (bottom-right) pixel.
  typedef enum int {
    TAP_BR = 0, TAP_BC = 1, TAP_BL = 2,
    TAP_MR = 3, TAP_MC = 4, TAP_ML = 5,
    TAP_TR = 6, TAP_TC = 7, TAP_TL = 8
  } tap_e;

  function automatic int byte_lsb(input int tap);
    return tap * PIX_W;
  endfunction

  // {1'b0,pixel} x coef, then one row of 3 products, then 3 rows.
  function automatic int prod_w(input int coef_w);
    return coef_w + PIX_W + 1;
  endfunction

  function automatic int row_w(input int coef_w);
    return coef_w + PIX_W + 3;
  endfunction

  function automatic int sum_w(input int coef_w);
    return coef_w + PIX_W + 4;
  endfunction

  function automatic int identity_coef(input int frac_bits);
    return 1 << frac_bits;
  endfunction

endpackage

// File: rtl/frac_conv3x3_coef_regfile.sv
// Nine run-time programmable mask coefficients; reset loads the identity mask
// (centre tap = 1.0, all others 0).
module frac_coef_regfile
  import frac_conv_pkg::*;
#(
  parameter int COEF_W    = 12,
  parameter int FRAC_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [3:0]                    addr,
  input  logic [COEF_W-1:0]             data,
  output logic [TAPS-1:0][COEF_W-1:0]   coef
);

  localparam logic [COEF_W-1:0] ID_COEF = COEF_W'(identity_coef(FRAC_BITS));

  logic [TAPS-1:0][COEF_W-1:0] coef_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++)
        coef_reg[i] <= (i == int'(TAP_MC)) ? ID_COEF : '0;
    end else if (we) begin
      // Addresses 9..15 match no tap and are silently dropped.
      for (int i = 0; i < TAPS; i++)
        if (addr == 4'(i))
          coef_reg[i] <= data;
    end
  end

  assign coef = coef_reg;

endmodule

// File: rtl/frac_conv3x3.sv
// 3-stage signed 9-tap weighted sum of a 3x3 window with rounding, saturation,
// border blanking and output position tracking. FRAC_ABS_EN: output |result|.
module frac_conv3x3
  import frac_conv_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int HIGHT     = 256,
  parameter int COEF_W    = 12,
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [71:0]       win_in,
  input  logic              win_valid,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  output logic [15:0]       out_col,
  output logic [15:0]       out_row,
  output logic              frame_done
);

  localparam int P_W = prod_w(COEF_W);
  localparam int R_W = row_w(COEF_W);
  localparam int S_W = sum_w(COEF_W);
  localparam logic signed [S_W-1:0] ROUND = S_W'(identity_coef(FRAC_BITS) >> 1);

  logic [TAPS-1:0][COEF_W-1:0] coef;

  frac_coef_regfile #(
    .COEF_W    (COEF_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_coef (
    .clk  (clk),
    .rst  (rst),
    .we   (coef_we),
    .addr (coef_addr),
    .data (coef_data),
    .coef (coef)
  );

  logic signed [P_W-1:0] prod_next [TAPS];
  logic signed [P_W-1:0] prod_reg  [TAPS];
  logic signed [R_W-1:0] rsum_next [3];
  logic signed [R_W-1:0] rsum_reg  [3];
  logic                  v1_reg, v2_reg;

  logic signed [S_W-1:0] sum_next, rounded, shifted;
  logic        [S_W-1:0] mag;
  logic        [7:0]     sat;

  logic [15:0] pos_col_reg, pos_row_reg;
  logic        last_col, last_row, border;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_prod
      // Both operands widened to the product width so the multiply is exact.
      assign prod_next[gi] =
        $signed({{(P_W-PIX_W){1'b0}}, win_in[byte_lsb(gi) +: PIX_W]}) *
        $signed({{(P_W-COEF_W){coef[gi][COEF_W-1]}}, coef[gi]});
    end
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign rsum_next[gi] = R_W'(prod_reg[3*gi]) + R_W'(prod_reg[3*gi+1]) +
                             R_W'(prod_reg[3*gi+2]);
    end
  endgenerate

  always_comb begin
    sum_next = S_W'(rsum_reg[0]) + S_W'(rsum_reg[1]) + S_W'(rsum_reg[2]);
    rounded  = sum_next + ROUND;
    shifted  = rounded >>> FRAC_BITS;
`ifdef FRAC_ABS_EN
    mag = shifted[S_W-1] ? -shifted : shifted;
`else
    mag = shifted[S_W-1] ? '0 : shifted;
`endif
    sat = (|mag[S_W-1:PIX_W]) ? 8'hFF : mag[PIX_W-1:0];
  end

  assign last_col = (pos_col_reg == 16'(WIDTH-1));
  assign last_row = (pos_row_reg == 16'(HIGHT-1));
  assign border   = (pos_col_reg == 16'd0) || last_col;

  // Datapath registers carry no reset; only the qualifiers do.
  always_ff @(posedge clk) begin
    if (enable) begin
      for (int i = 0; i < TAPS; i++) prod_reg[i] <= prod_next[i];
      for (int r = 0; r < 3; r++)    rsum_reg[r] <= rsum_next[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_out     <= '0;
      out_col     <= '0;
      out_row     <= '0;
      frame_done  <= 1'b0;
      pos_col_reg <= '0;
      pos_row_reg <= '0;
    end else if (enable) begin
      v1_reg    <= win_valid;
      v2_reg    <= v1_reg;
      pix_valid <= v2_reg;
      if (v2_reg) begin
        pix_out    <= border ? 8'd0 : sat;
        out_col    <= pos_col_reg;
        out_row    <= pos_row_reg;
        frame_done <= last_col && last_row;
        if (last_col) begin
          pos_col_reg <= '0;
          pos_row_reg <= last_row ? 16'd0 : pos_row_reg + 16'd1;
        end else begin
          pos_col_reg <= pos_col_reg + 16'd1;
        end
      end else begin
        frame_done <= 1'b0;
        // Stream ended early: restart position tracking at the frame origin.
        if (pix_valid) begin
          pos_col_reg <= '0;
          pos_row_reg <= '0;
          out_col     <= '0;
          out_row     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_conv3x3.sv
// Bench for frac_conv3x3 (WIDTH=HIGHT=4): table of mask/window vectors plus
// hand sequences for same-cycle writes, framing, enable stall and reset.
module tb_frac_conv3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst, enable, win_valid, coef_we;
  logic [71:0] win_in;
  logic [3:0]  coef_addr;
  logic [11:0] coef_data;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic [15:0] out_col, out_row;
  logic        frame_done;

  always #5 clk = ~clk;

  frac_conv3x3 #(.WIDTH(W), .HIGHT(H), .COEF_W(12), .FRAC_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .win_in     (win_in),
    .win_valid  (win_valid),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .out_col    (out_col),
    .out_row    (out_row),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [7:0]  pix;
    logic [15:0] col;
    logic [15:0] row;
    logic        fd;
  } exp_t;

  typedef struct packed {
    logic [107:0] coef;
    logic [71:0]  win;
    logic [7:0]   exp_pix;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic mon_en;
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mcol = 0, mrow = 0;
  bit   last_v = 1'b0;
  logic [7:0]  rec_pix;
  logic [15:0] rec_col, rec_row;
  logic        rec_valid;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Scoreboard: one line per delivered beat.
  always @(posedge clk) begin
    mon_en = enable && !rst;
    #1;
    if (mon_en && !rst && pix_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got pix %0d at (%0d,%0d), required no beat",
                 pix_out, out_col, out_row);
      end else begin
        mon_e = sbq.pop_front();
        $display("beat col=%0d row=%0d pix=%0d fd=%0d (exp pix=%0d)",
                 out_col, out_row, pix_out, frame_done, mon_e.pix);
        check("beat_pix", pix_out, mon_e.pix);
        check("beat_col", out_col, mon_e.col);
        check("beat_row", out_row, mon_e.row);
        check("beat_fd", frame_done, mon_e.fd);
      end
    end
  end

  // One clock of stimulus; pushes the expected beat for every accepted window.
  task automatic step(input bit en, input bit v, input logic [71:0] w, input int exp_inner,
                      input bit we = 1'b0, input logic [3:0] a = 4'd0,
                      input logic [11:0] d = 12'd0);
    enable = en; win_valid = v; win_in = w;
    coef_we = we; coef_addr = a; coef_data = d;
    if (en) begin
      if (v) begin
        exp_t e;
        e.pix = (mcol == 0 || mcol == W-1) ? 8'd0 : 8'(exp_inner);
        e.col = 16'(mcol);
        e.row = 16'(mrow);
        e.fd  = (mcol == W-1) && (mrow == H-1);
        sbq.push_back(e);
        if (mcol == W-1) begin
          mcol = 0;
          mrow = (mrow == H-1) ? 0 : mrow + 1;
        end else begin
          mcol++;
        end
      end else if (last_v) begin
        mcol = 0;
        mrow = 0;
      end
      last_v = v;
    end
    @(negedge clk);
  endtask

  task automatic write_coefs(input logic [107:0] c);
    for (int t = 0; t < 9; t++)
      step(1'b1, 1'b0, 72'd0, 0, 1'b1, 4'(t), c[t*12 +: 12]);
  endtask

  function automatic logic [71:0] mk_win(input logic [7:0] centre, input logic [7:0] others);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = (i == 4) ? centre : others;
    return w;
  endfunction

  function automatic logic [107:0] ident();
    logic [107:0] c;
    c = '0;
    c[4*12 +: 12] = 12'h100;
    return c;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; win_valid = 1'b0; win_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (2) @(negedge clk);
    check("rst_pix_out", pix_out, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_row", out_row, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Identity mask straight out of reset, no writes.
    for (int k = 0; k < W; k++) step(1'b1, 1'b1, {9{8'd100}}, 100);
    repeat (4) step(1'b1, 1'b0, 72'd0, 0);

    vecs[0] = '{coef: ident(), win: {9{8'd100}}, exp_pix: 8'd100};
    vecs[1].coef = '0; vecs[1].coef[4*12 +: 12] = 12'hF00;
    vecs[1].win  = mk_win(8'd50, 8'd100);
`ifdef FRAC_ABS_EN
    vecs[1].exp_pix = 8'd50;
`else
    vecs[1].exp_pix = 8'd0;
`endif
    vecs[2].coef = {9{12'h100}}; vecs[2].win = {9{8'd255}}; vecs[2].exp_pix = 8'd255;
    vecs[3].coef = '0; vecs[3].coef[11:0] = 12'h080;
    vecs[3].win  = 72'd3; vecs[3].exp_pix = 8'd2;
    vecs[4].coef = '0; vecs[4].coef[11:0] = 12'hF80;
    vecs[4].win  = 72'd3;
`ifdef FRAC_ABS_EN
    vecs[4].exp_pix = 8'd1;
`else
    vecs[4].exp_pix = 8'd0;
`endif
    vecs[5].coef = '0; vecs[5].coef[4*12 +: 12] = 12'h400;
    for (int t = 1; t < 9; t += 2) vecs[5].coef[t*12 +: 12] = 12'hF00;
    vecs[5].win = mk_win(8'd60, 8'd10); vecs[5].exp_pix = 8'd200;
    vecs[6].coef = '0; vecs[6].coef[8*12 +: 12] = 12'h040;
    vecs[6].win  = {8'd10, 64'd0}; vecs[6].exp_pix = 8'd3;
    vecs[7].coef = {9{12'h800}}; vecs[7].win = {9{8'd255}};
`ifdef FRAC_ABS_EN
    vecs[7].exp_pix = 8'd255;
`else
    vecs[7].exp_pix = 8'd0;
`endif

    for (int n = 0; n < 8; n++) begin
      write_coefs(vecs[n].coef);
      for (int k = 0; k < W; k++) step(1'b1, 1'b1, vecs[n].win, int'(vecs[n].exp_pix));
      repeat (4) step(1'b1, 1'b0, 72'd0, 0);
    end

    // Same-cycle write: the window sampled alongside it still sees the old tap.
    write_coefs(ident());
    step(1'b1, 1'b1, mk_win(8'd40, 8'd7), 0);
    step(1'b1, 1'b1, mk_win(8'd40, 8'd7), 40, 1'b1, 4'd4, 12'h200);
    step(1'b1, 1'b1, mk_win(8'd40, 8'd7), 80);
    step(1'b1, 1'b1, mk_win(8'd40, 8'd7), 80);
    // Out-of-range addresses must not alias onto real taps.
    step(1'b1, 1'b0, 72'd0, 0, 1'b1, 4'd9,  12'h7FF);
    step(1'b1, 1'b0, 72'd0, 0, 1'b1, 4'd12, 12'h7FF);
    step(1'b1, 1'b0, 72'd0, 0, 1'b1, 4'd15, 12'h7FF);
    for (int k = 0; k < W; k++) step(1'b1, 1'b1, mk_win(8'd30, 8'd20), 60);
    repeat (4) step(1'b1, 1'b0, 72'd0, 0);

    // Full 4x4 frame with a two-cycle enable stall in the middle.
    write_coefs(ident());
    for (int k = 0; k < W*H; k++) begin
      step(1'b1, 1'b1, mk_win(8'(10 + k), 8'($urandom_range(0, 255))), 10 + k);
      if (k == 7) begin
        rec_pix = pix_out; rec_col = out_col; rec_row = out_row; rec_valid = pix_valid;
        for (int s = 0; s < 2; s++) begin
          step(1'b0, 1'b1, mk_win(8'd222, 8'd222), 0);
          check("stall_pix", pix_out, rec_pix);
          check("stall_col", out_col, rec_col);
          check("stall_row", out_row, rec_row);
          check("stall_valid", pix_valid, rec_valid);
        end
      end
    end
    step(1'b1, 1'b1, mk_win(8'd99, 8'd1), 99);
    step(1'b1, 1'b1, mk_win(8'd98, 8'd1), 98);
    repeat (4) step(1'b1, 1'b0, 72'd0, 0);

    // Reset with the pipeline full, then confirm the identity mask is back.
    write_coefs({84'd0, 12'h000, 12'h000, 12'h100} & ~ident());
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, mk_win(8'd77, 8'd5), 5);
    check("pre_rst_valid", pix_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_pix_out", pix_out, 0);
    check("midrst_out_col", out_col, 0);
    check("midrst_frame_done", frame_done, 0);
    sbq.delete();
    mcol = 0; mrow = 0; last_v = 1'b0;
    enable = 1'b1; win_valid = 1'b0; coef_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < W; k++) step(1'b1, 1'b1, {32'h05050505, 8'd77, 32'h05050505}, 77);
    repeat (5) step(1'b1, 1'b0, 72'd0, 0);

    check("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_conv3x3.md
Name: frac_conv3x3

Overview:
- Downstream consumer of the 3x3 window line buffer.
- Takes each valid 72-bit window and forms a 9-tap signed fixed-point weighted sum, using run-time programmable fractional-order mask coefficients.
- Rounds and saturates the sum to an 8-bit pixel, zeroes horizontally wrapped border columns, and tracks the output pixel position and frame completion.
- Feeds the output pixel writer / result memory.

Parameters:
- WIDTH, 256, image width in pixels.
- HIGHT, 256, image height in pixels.
- COEF_W, 12, coefficient width, signed two's complement.
- FRAC_BITS, 8, fractional bits in each coefficient.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  pipeline advance; when low, all registers hold.
- win_in  in  72  3x3 window; byte i = bits [i*8+7:i*8]; byte 0 newest (bottom-right), byte 8 oldest (top-left); pixels unsigned.
- win_valid  in  1  window qualifier (driven by upstream FilterFlag).
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  tap index 0..8; indices 9..15 ignored.
- coef_data  in  COEF_W  signed coefficient value.
- pix_out  out  8  result pixel.
- pix_valid  out  1  pix_out qualifier.
- out_col  out  16  column of pix_out.
- out_row  out  16  row of pix_out.
- frame_done  out  1  one-cycle pulse with the last pixel of a frame.

Behaviour:
- Reset, asynchronous:
  - pix_out=0, pix_valid=0, out_col=0, out_row=0, frame_done=0.
  - All pipeline valids cleared.
  - Coefficients reset to identity: tap 4 = 1<<FRAC_BITS, all other taps 0.
- Coefficient write:
  - Acts on the posedge when coef_we=1, independent of enable.
  - A window sampled in the same cycle uses the old value.
  - Addresses above 8 leave all coefficients unchanged.
- Pipeline, with enable=1; latency 3 cycles from win_valid sampled to pix_valid:
  - S1: register 9 products, each {1'b0,pixel} x coef, signed, COEF_W+9 bits.
  - S2: register 3 row sums (taps 0-2, 3-5, 6-8), each COEF_W+11 bits.
  - S3: full sum (COEF_W+12 bits), add 1<<(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, saturate to 0..255, register into pix_out.
  - No internal overflow is possible with these widths.
- enable=0: every pipeline stage, valid and counter holds. Inputs are not sampled. pix_valid holds its value but does not count as a new pixel.
- Position counters:
  - Advance on each pix_valid beat: out_col increments; at WIDTH-1 it wraps to 0 and out_row increments.
  - At col=WIDTH-1 and row=HIGHT-1: frame_done=1 with that beat, then both counters return to 0.
- Border: on beats where the column counter is 0 or WIDTH-1, pix_out is forced to 0 (pix_valid still 1). This suppresses windows that straddle two rows.
- Resync: a falling edge of the S3-stage valid, observed with enable=1, clears out_col and out_row. This covers a partial frame or upstream restart.
- rst mid-frame: output and state clear immediately; coefficients return to identity.
- Back-to-back windows: one window accepted per cycle, full throughput, no backpressure.

Optional Feature:
- Macro: FRAC_ABS_EN.
- Defined: S3 takes the absolute value of the shifted sum before saturating to 255, giving edge magnitude.
- Undefined: negative results saturate to 0.

Decomposition:
- Package frac_conv_pkg:
  - Constants: TAPS=9, PIX_W=8, window byte-index mapping.
  - Derived widths: PROD_W, ROW_W, SUM_W.
  - Identity coefficient value.
- Sub-module frac_coef_regfile: 9 x COEF_W registers with the write port and reset-to-identity.

Test Plan:
- Identity coefficients; window bytes all 100; centre column (col 1) -> pix_out=100 exactly 3 cycles after win_valid; col 0 beat -> pix_out=0.
- Write tap4=-256 and all other taps 0; window centre=50 -> pix_out=0 without FRAC_ABS_EN, 50 with it.
- All 9 taps=+256; all bytes 255 -> sum 2295, saturates -> pix_out=255.
- Tap0=128 (0.5), newest byte=3, others 0 -> 1.5 rounds to pix_out=2.
- Stream WIDTH*HIGHT=16 windows with WIDTH=HIGHT=4 -> frame_done on the 16th beat with out_row=3, out_col=3; next beat reports (0,0). Toggle enable=0 for 2 cycles mid-stream -> outputs and counters frozen.
- Assert rst while the pipeline is full -> pix_valid drops that cycle; coefficients read back as identity (verify with a centre-pixel window after reset).
